up_top: RTL and testbench
=========================

UP_TOP -- requirements
Module: up_top

Interface
REQ-001 Parameter FIFO_WIDTH, default 14, sample width in bits (unsigned offset-binary DAC code).
REQ-002 Parameter FIFO_DEPTH, default 64, FIFO capacity in samples (power of two).
REQ-003 Parameter US_PARAM, default 4, upsampling ratio exponent; one sample consumed per 2^US_PARAM clocks.
REQ-004 Parameter ALMST_EMPTY_THRESH, default 4, almost-empty level in samples.
REQ-005 One clock; reset is asynchronous and active-low: clk input 1, rising-edge clock; rst_n input 1, reset.
REQ-006 wr_en  input  1  write strobe, one sample per clk cycle high.
REQ-007 wr_data  input  FIFO_WIDTH  sample to write.
REQ-008 dac_dataA_out  output  FIFO_WIDTH  zero-order-hold upsampled stream.
REQ-009 dac_dataB_out  output  FIFO_WIDTH  linearly interpolated upsampled stream.
REQ-010 fifo_full  output  1  FIFO count == FIFO_DEPTH.
REQ-011 fifo_empty  output  1  FIFO count == 0.
REQ-012 fifo_almst_empty  output  1  FIFO count <= ALMST_EMPTY_THRESH.

Function
REQ-013 A write occurs on a clk edge with wr_en=1 and fifo_full=0; a write while full is dropped and the FIFO is unchanged.
REQ-014 Flags are registered and derived from an internal count of width log2(FIFO_DEPTH)+1; they reflect the count after each edge.
REQ-015 Simultaneous write and read in one cycle leaves the count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-016 A free-running US_PARAM-bit phase counter increments every clk, wrapping from 2^US_PARAM-1 to 0.
REQ-017 A pop is issued when phase == 2^US_PARAM-1 and fifo_empty=0; no other reads occur.
REQ-018 FIFO read data is registered and valid in the cycle after the pop (phase 0).
REQ-019 At phase 0, prev <= cur; cur <= popped sample if a pop occurred, otherwise cur is held (underflow hold).
REQ-020 dac_dataA_out is registered as cur, so a popped sample appears at the output 2 cycles after its pop and persists for 2^US_PARAM cycles.
REQ-021 Interpolation index k = (phase - 1) mod 2^US_PARAM, so k=0 in the first cycle after the prev/cur update.
REQ-022 dac_dataB_out is registered as prev + floor(((cur - prev) * k) / 2^US_PARAM), with signed arithmetic of width FIFO_WIDTH+US_PARAM+1 and the result truncated to FIFO_WIDTH bits; the result always lies between prev and cur inclusive.
REQ-023 Under underflow, prev equals cur after the next phase-0 update, so dac_dataB_out settles flat at cur.
REQ-024 Writes are accepted at any phase; the data path imposes no backpressure beyond fifo_full.

Reset
REQ-025 While rst_n=0, asynchronously: pointers, count, phase, prev, cur, dac_dataA_out and dac_dataB_out are 0; fifo_empty=1, fifo_almst_empty=1, fifo_full=0.
REQ-026 Reset asserted mid-operation discards all FIFO contents; after release the phase restarts at 0.

Structure
REQ-027 Constants FIFO_WIDTH, FIFO_DEPTH, US_PARAM and ALMST_EMPTY_THRESH defaults belong in shared package up_top_pkg.
REQ-028 The FIFO is one sub-module, sync_fifo (write/read ports, count, full/empty/almost-empty flags); up_top holds the phase counter, prev/cur registers and interpolator.

Verification
REQ-029 Reset check: hold rst_n=0 for 2 cycles -> both outputs 0, fifo_empty=1, fifo_almst_empty=1, fifo_full=0.
REQ-030 Single sample: write 896 once after reset -> dac_dataA_out=896 two cycles after the next phase-15 pop; dac_dataB_out ramps 0,56,112,...,840 over 16 cycles (with prev=0), then flat at 896.
REQ-031 Sequence: write 0,2,8,24,64,160,384,896, one every 2 cycles -> dac_dataA_out steps through the values in order, each held 16 cycles; dac_dataB_out is monotonic between consecutive values.
REQ-032 Overflow: repeat 8 writes every 18 cycles indefinitely -> count grows; fifo_full=1 at 64; extra writes dropped; count never exceeds 64.
REQ-033 Underflow: stop writing -> fifo_almst_empty=1 at count<=4, fifo_empty=1 at 0; dac_dataA_out holds last sample; dac_dataB_out settles flat at the last sample.
REQ-034 Mid-run reset: assert rst_n=0 with FIFO half full -> all flags and outputs at reset values immediately; the first post-reset write is the first sample output.

Source files
------------

// File: rtl/up_top_pkg.sv
// up_top_pkg: shared default parameters for the upsampling DAC feeder.
package up_top_pkg;
    localparam int DEF_FIFO_WIDTH         = 14;
    localparam int DEF_FIFO_DEPTH         = 64;
    localparam int DEF_US_PARAM           = 4;
    localparam int DEF_ALMST_EMPTY_THRESH = 4;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data and registered level flags.
module sync_fifo import up_top_pkg::*; #(
    parameter int WIDTH = DEF_FIFO_WIDTH,
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int ALMST = DEF_ALMST_EMPTY_THRESH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             almst_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [AW:0]      cnt, cnt_nxt;
    logic             wr, rd;
    assign wr      = wr_en && !full;
    assign rd      = rd_en && !empty;
    assign cnt_nxt = cnt + (AW+1)'(wr) - (AW+1)'(rd);
    always_ff @(posedge clk)
        if (wr) mem[wptr] <= wr_data;
    // flags come from the next count so they track the count after each edge
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wptr        <= '0;
            rptr        <= '0;
            cnt         <= '0;
            rd_data     <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            almst_empty <= 1'b1;
        end else begin
            if (wr) wptr <= wptr + AW'(1);
            if (rd) begin
                rptr    <= rptr + AW'(1);
                rd_data <= mem[rptr];
            end
            cnt         <= cnt_nxt;
            full        <= cnt_nxt == (AW+1)'(DEPTH);
            empty       <= cnt_nxt == '0;
            almst_empty <= cnt_nxt <= (AW+1)'(ALMST);
        end
endmodule

// File: rtl/up_top.sv
// up_top: FIFO-fed upsampler producing zero-order-hold and linearly interpolated DAC streams.
module up_top import up_top_pkg::*; #(
    parameter int FIFO_WIDTH         = DEF_FIFO_WIDTH,
    parameter int FIFO_DEPTH         = DEF_FIFO_DEPTH,
    parameter int US_PARAM           = DEF_US_PARAM,
    parameter int ALMST_EMPTY_THRESH = DEF_ALMST_EMPTY_THRESH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [FIFO_WIDTH-1:0] wr_data,
    output logic [FIFO_WIDTH-1:0] dac_dataA_out,
    output logic [FIFO_WIDTH-1:0] dac_dataB_out,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  fifo_almst_empty
);
    localparam int IW = FIFO_WIDTH + US_PARAM + 1;
    logic [US_PARAM-1:0]   phase, k;
    logic                  pop, pop_d;
    logic [FIFO_WIDTH-1:0] rd_data, prev, cur;
    logic signed [IW-1:0]  diff, prod, sum;
    sync_fifo #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .ALMST (ALMST_EMPTY_THRESH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (pop),
        .rd_data     (rd_data),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .almst_empty (fifo_almst_empty)
    );
    assign pop  = (&phase) && !fifo_empty;
    assign k    = phase - US_PARAM'(1);
    // arithmetic shift floors toward minus infinity, keeping the result between prev and cur
    assign diff = $signed(IW'(cur)) - $signed(IW'(prev));
    assign prod = diff * $signed(IW'(k));
    assign sum  = $signed(IW'(prev)) + (prod >>> US_PARAM);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            phase         <= '0;
            pop_d         <= 1'b0;
            prev          <= '0;
            cur           <= '0;
            dac_dataA_out <= '0;
            dac_dataB_out <= '0;
        end else begin
            phase <= phase + US_PARAM'(1);
            pop_d <= pop;
            if (phase == '0) begin
                prev <= cur;
                if (pop_d) cur <= rd_data;
            end
            dac_dataA_out <= cur;
            dac_dataB_out <= FIFO_WIDTH'(sum);
        end
endmodule

// File: tb/tb_up_top.sv
// tb_up_top: table vectors, directed sequences and randomized traffic against a queue-based model.
module tb_up_top;
    import up_top_pkg::*;
    localparam int W  = DEF_FIFO_WIDTH;
    localparam int D  = DEF_FIFO_DEPTH;
    localparam int N  = 1 << DEF_US_PARAM;
    localparam int TH = DEF_ALMST_EMPTY_THRESH;

    typedef struct {
        bit wr;
        int d;
        int ea;
        int eb;
        bit emp;
    } vec_t;

    logic         clk = 0, rst_n = 0, wr_en = 0;
    logic [W-1:0] wr_data = '0;
    logic [W-1:0] dac_a, dac_b;
    logic         full, empty, almst;
    int checks = 0, errors = 0;

    int q[$];
    int ph, cur, prev, pend, last, ea, eb;
    bit pend_v;
    vec_t tbl[40];
    int vals[8] = '{0, 2, 8, 24, 64, 160, 384, 896};

    up_top dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .wr_en            (wr_en),
        .wr_data          (wr_data),
        .dac_dataA_out    (dac_a),
        .dac_dataB_out    (dac_b),
        .fifo_full        (full),
        .fifo_empty       (empty),
        .fifo_almst_empty (almst)
    );

    always #5 clk = ~clk;

    function automatic int fdiv(input int x);
        return x >= 0 ? x / N : -((-x + N - 1) / N);
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset;
        q.delete();
        ph = 0; cur = 0; prev = 0; pend = 0; pend_v = 0; ea = 0; eb = 0; last = 0;
    endtask

    task automatic m_step(input bit w, input int d);
        int k, na, nb;
        bit was_full;
        k  = (ph + N - 1) % N;
        na = cur;
        nb = (prev + fdiv((cur - prev) * k)) & ((1 << W) - 1);
        was_full = q.size() == D;
        if (ph == 0) begin
            prev = cur;
            if (pend_v) cur = pend;
        end
        pend_v = 0;
        if (ph == N - 1 && q.size() > 0) begin
            pend   = q.pop_front();
            pend_v = 1;
        end
        if (w && !was_full) begin
            q.push_back(d);
            last = d;
        end
        ph = (ph + 1) % N;
        ea = na;
        eb = nb;
    endtask

    task automatic check_all;
        check("dac_a", int'(dac_a), ea);
        check("dac_b", int'(dac_b), eb);
        check("fifo_empty", int'(empty), int'(q.size() == 0));
        check("fifo_almst_empty", int'(almst), int'(q.size() <= TH));
        check("fifo_full", int'(full), int'(q.size() == D));
    endtask

    task automatic tick(input bit w, input int d);
        wr_en   = w;
        wr_data = W'(d);
        m_step(w, d);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset;
        wr_en = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        m_reset();
        check_all();
        rst_n = 1;
    endtask

    initial begin
        int lastb;
        bit saw_full;
        for (int i = 0; i < 40; i++) begin
            int n;
            n = i + 1;
            tbl[i].wr  = n == 1;
            tbl[i].d   = 896;
            tbl[i].ea  = n >= 18 ? 896 : 0;
            tbl[i].eb  = n < 18 ? 0 : (n <= 33 ? 56 * (n - 18) : 896);
            tbl[i].emp = n > 15;
        end

        do_reset();
        for (int i = 0; i < 40; i++) begin
            tick(tbl[i].wr, tbl[i].d);
            check("ramp_a", int'(dac_a), tbl[i].ea);
            check("ramp_b", int'(dac_b), tbl[i].eb);
            check("ramp_empty", int'(empty), int'(tbl[i].emp));
        end

        do_reset();
        lastb = 0;
        for (int n = 1; n <= 160; n++) begin
            tick(n % 2 == 1 && n <= 15, n <= 15 ? vals[(n - 1) / 2] : 0);
            if (n >= 18 && n < 18 + 8 * N) check("seq_hold", int'(dac_a), vals[(n - 18) / N]);
            check("seq_mono", int'(int'(dac_b) >= lastb), 1);
            lastb = int'(dac_b);
        end

        do_reset();
        saw_full = 0;
        for (int r = 0; r < 30; r++)
            for (int j = 0; j < 18; j++) begin
                tick(j < 8, int'($urandom_range(0, (1 << W) - 1)));
                if (full) saw_full = 1;
            end
        check("ovf_full_seen", int'(saw_full), 1);

        repeat (D * N + 40) tick(0, 0);
        check("unf_a", int'(dac_a), last);
        check("unf_b", int'(dac_b), last);
        check("unf_empty", int'(empty), 1);

        repeat (400) tick($urandom_range(0, 3) == 0, int'($urandom_range(0, (1 << W) - 1)));

        repeat (32) tick(1, int'($urandom_range(0, (1 << W) - 1)));
        #2 rst_n = 0;
        #1;
        m_reset();
        check_all();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1;
        tick(1, 12345);
        repeat (40) tick(0, 0);
        check("mid_first", int'(dac_a), 12345);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
